// File: rtl/aq_axi_sdma64_intctrl.sv
// SDMA64 interrupt controller: per-channel edge/level capture into pending bits,
// mask and write-1-to-clear, count/timeout coalescing into one registered IRQ.
module aq_axi_sdma64_intctrl #(
  parameter int CH    = 4,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CH-1:0]    INT_IN,
  input  logic [CH-1:0]    MODE,
  input  logic [CH-1:0]    MASK,
  input  logic [CH-1:0]    CLR,
  input  logic [CNT_W-1:0] COAL_CNT,
  input  logic [TMO_W-1:0] COAL_TMO,
  output logic [CH-1:0]    PENDING,
  output logic             IRQ,
  output logic             IRQ_PULSE,
  output logic [CNT_W-1:0] EVT_CNT
);

  localparam int N_W = $clog2(CH + 1);
  localparam int SW  = 33;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COAL   = 2'd1,
    ST_ASSERT = 2'd2
  } state_e;

  function automatic logic [N_W-1:0] popcount(input logic [CH-1:0] v);
    logic [N_W-1:0] c;
    c = '0;
    for (int i = 0; i < CH; i++) begin
      c = c + N_W'(v[i]);
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CH-1:0]    prev_q, prev_d;
  logic [CH-1:0]    pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic             irq_q, irq_d;
  logic             pulse_q, pulse_d;

  logic [CH-1:0]    evt_s;
  logic [CH-1:0]    new_s;
  logic [N_W-1:0]   n_s;
  logic             act_s;
  logic [SW-1:0]    n_ext_s;
  logic [SW-1:0]    thr_s;
  logic [SW-1:0]    sum_s;
  logic [CNT_W-1:0] cnt_sat_s;
  logic [TMO_W-1:0] timer_inc_s;

  // Capture, pending update and the saturating event arithmetic.
  always_comb begin
    evt_s       = INT_IN & (MODE | ~prev_q);
    prev_d      = INT_IN;
    pending_d   = (pending_q & ~CLR) | evt_s;
    new_s       = evt_s & MASK & ~pending_q;
    n_s         = popcount(new_s);
    act_s       = |(pending_q & MASK);
    n_ext_s     = SW'(n_s);
    thr_s       = SW'(COAL_CNT);
    sum_s       = SW'(cnt_q) + n_ext_s;
    cnt_sat_s   = (sum_s > SW'(CNT_MAX)) ? CNT_MAX : sum_s[CNT_W-1:0];
    timer_inc_s = timer_q + TMO_W'(1);
  end

  // Coalescing FSM: next state, window counter, timer and IRQ outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        timer_d = '0;
        if ((n_s != '0) && ((thr_s <= 33'd1) || (n_ext_s >= thr_s))) begin
          state_d = ST_ASSERT;
        end else if (n_s != '0) begin
          state_d = ST_COAL;
          cnt_d   = cnt_sat_s;
        end else if (act_s) begin
          state_d = ST_ASSERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COAL: begin
        cnt_d   = cnt_sat_s;
        timer_d = timer_inc_s;
        if (SW'(cnt_sat_s) >= thr_s) begin
          state_d = ST_ASSERT;
        end else if ((COAL_TMO != '0) && (timer_inc_s == COAL_TMO)) begin
          state_d = ST_ASSERT;
        end else if (!act_s && (n_s == '0)) begin
          // everything pending was cleared or masked before the window fired
          state_d = ST_IDLE;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          state_d = ST_COAL;
        end
      end
      ST_ASSERT: begin
        if (!act_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          state_d = ST_ASSERT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
    irq_d   = (state_d == ST_ASSERT);
    pulse_d = (state_d == ST_ASSERT) && (state_q != ST_ASSERT);
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      irq_q     <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      irq_q     <= irq_d;
      pulse_q   <= pulse_d;
    end
  end

  assign PENDING   = pending_q;
  assign IRQ       = irq_q;
  assign IRQ_PULSE = pulse_q;
  assign EVT_CNT   = cnt_q;

endmodule

// File: tb/tb_aq_axi_sdma64_intctrl.sv
// Self-checking bench for aq_axi_sdma64_intctrl: vector table, directed corner
// sequences, a narrow-counter saturation instance and a randomized model run.
module tb_aq_axi_sdma64_intctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  int_in, mode, mask, clr;
  logic [7:0]  coal_cnt;
  logic [15:0] coal_tmo;
  logic [3:0]  pending;
  logic        irq, irq_pulse;
  logic [7:0]  evt_cnt;

  logic [4:0]  s_int, s_mode, s_mask, s_clr;
  logic [1:0]  s_thr;
  logic [3:0]  s_tmo;
  logic [4:0]  s_pending;
  logic        s_irq, s_pulse;
  logic [1:0]  s_evt;

  aq_axi_sdma64_intctrl #(.CH(4), .CNT_W(8), .TMO_W(16)) u_dut (
    .CLK(clk), .RST(rst), .INT_IN(int_in), .MODE(mode), .MASK(mask), .CLR(clr),
    .COAL_CNT(coal_cnt), .COAL_TMO(coal_tmo), .PENDING(pending), .IRQ(irq),
    .IRQ_PULSE(irq_pulse), .EVT_CNT(evt_cnt)
  );

  aq_axi_sdma64_intctrl #(.CH(5), .CNT_W(2), .TMO_W(4)) u_sat (
    .CLK(clk), .RST(rst), .INT_IN(s_int), .MODE(s_mode), .MASK(s_mask), .CLR(s_clr),
    .COAL_CNT(s_thr), .COAL_TMO(s_tmo), .PENDING(s_pending), .IRQ(s_irq),
    .IRQ_PULSE(s_pulse), .EVT_CNT(s_evt)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] int_v;
    logic [3:0] clr_v;
    logic [7:0] thr;
    logic [3:0] pend;
    logic       irq;
    logic       pulse;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic expect4(input string tag, input logic [3:0] p, input logic i,
                         input logic pu, input logic [7:0] c);
    check({tag, ".pend"},  32'(pending),   32'(p));
    check({tag, ".irq"},   32'(irq),       32'(i));
    check({tag, ".pulse"}, 32'(irq_pulse), 32'(pu));
    check({tag, ".cnt"},   32'(evt_cnt),   32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model state for the random run
  bit [3:0] m_prev, m_pend, evt;
  bit       m_fire, m_gath, m_pulse, was_fire, act, seen;
  int       m_cnt, m_age, n;

  initial begin
    rst = 1'b1; int_in = 4'd0; mode = 4'd0; mask = 4'hF; clr = 4'd0;
    coal_cnt = 8'd1; coal_tmo = 16'd0;
    s_int = 5'd0; s_mode = 5'd0; s_mask = 5'h1F; s_clr = 5'd0; s_thr = 2'd3; s_tmo = 4'd0;
    tick(); tick();
    expect4("reset", 4'd0, 1'b0, 1'b0, 8'd0);
    check("reset.s_cnt", 32'(s_evt), 32'd0);
    check("reset.s_irq", 32'(s_irq), 32'd0);
    rst = 1'b0;

    // {int_in, clr, coal_cnt, exp pending, exp irq, exp pulse, exp evt_cnt}
    vecs[0]  = '{4'b0000, 4'b0000, 8'd1, 4'b0000, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{4'b0100, 4'b0000, 8'd1, 4'b0100, 1'b1, 1'b1, 8'd0};
    vecs[2]  = '{4'b0000, 4'b0000, 8'd1, 4'b0100, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{4'b0000, 4'b0100, 8'd1, 4'b0000, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{4'b0000, 4'b0000, 8'd1, 4'b0000, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{4'b0001, 4'b0000, 8'd3, 4'b0001, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{4'b0000, 4'b0000, 8'd3, 4'b0001, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{4'b0010, 4'b0000, 8'd3, 4'b0011, 1'b0, 1'b0, 8'd2};
    vecs[8]  = '{4'b0000, 4'b0000, 8'd3, 4'b0011, 1'b0, 1'b0, 8'd2};
    vecs[9]  = '{4'b1000, 4'b0000, 8'd3, 4'b1011, 1'b1, 1'b1, 8'd3};
    vecs[10] = '{4'b0000, 4'b0000, 8'd3, 4'b1011, 1'b1, 1'b0, 8'd3};
    vecs[11] = '{4'b0000, 4'b1111, 8'd3, 4'b0000, 1'b1, 1'b0, 8'd3};
    vecs[12] = '{4'b0000, 4'b0000, 8'd3, 4'b0000, 1'b0, 1'b0, 8'd0};
    vecs[13] = '{4'b0010, 4'b0000, 8'd1, 4'b0010, 1'b1, 1'b1, 8'd0};
    vecs[14] = '{4'b0000, 4'b0000, 8'd1, 4'b0010, 1'b1, 1'b0, 8'd0};
    vecs[15] = '{4'b0010, 4'b0010, 8'd1, 4'b0010, 1'b1, 1'b0, 8'd0};
    vecs[16] = '{4'b0000, 4'b0010, 8'd1, 4'b0000, 1'b1, 1'b0, 8'd0};
    vecs[17] = '{4'b0000, 4'b0000, 8'd1, 4'b0000, 1'b0, 1'b0, 8'd0};
    for (int v = 0; v < 18; v++) begin
      int_in = vecs[v].int_v; clr = vecs[v].clr_v; coal_cnt = vecs[v].thr;
      tick();
      expect4($sformatf("vec%0d", v), vecs[v].pend, vecs[v].irq, vecs[v].pulse, vecs[v].cnt);
    end

    // masked level source, then unmask, then clear while still high
    mode = 4'b0001; mask = 4'b1110; int_in = 4'b0001; coal_cnt = 8'd1;
    tick(); expect4("lvl.masked", 4'b0001, 1'b0, 1'b0, 8'd0);
    tick(); expect4("lvl.masked2", 4'b0001, 1'b0, 1'b0, 8'd0);
    mask = 4'b1111;
    tick(); expect4("lvl.unmask", 4'b0001, 1'b1, 1'b1, 8'd0);
    clr = 4'b0001;
    tick(); expect4("lvl.clr_high", 4'b0001, 1'b1, 1'b0, 8'd0);
    int_in = 4'b0000;
    tick(); expect4("lvl.clr_low", 4'b0000, 1'b1, 1'b0, 8'd0);
    clr = 4'b0000;
    tick(); expect4("lvl.idle", 4'b0000, 1'b0, 1'b0, 8'd0);
    mode = 4'b0000;

    // timeout fires after k+10
    coal_cnt = 8'd8; coal_tmo = 16'd10; int_in = 4'b0010;
    tick(); expect4("tmo.k", 4'b0010, 1'b0, 1'b0, 8'd1);
    int_in = 4'b0000;
    for (int j = 1; j < 10; j++) tick();
    expect4("tmo.k9", 4'b0010, 1'b0, 1'b0, 8'd1);
    tick(); expect4("tmo.k10", 4'b0010, 1'b1, 1'b1, 8'd1);
    clr = 4'b0010; tick(); clr = 4'b0000; tick();
    expect4("tmo.done", 4'b0000, 1'b0, 1'b0, 8'd0);

    // timeout window abandoned by clearing at k+5
    int_in = 4'b0010; tick(); int_in = 4'b0000;
    for (int j = 1; j < 5; j++) tick();
    clr = 4'b0010; tick(); clr = 4'b0000;
    tick(); expect4("tmo_abort.k6", 4'b0000, 1'b0, 1'b0, 8'd0);
    seen = 1'b0;
    for (int j = 7; j < 14; j++) begin
      tick();
      if (irq) seen = 1'b1;
    end
    check("tmo_abort.never", 32'(seen), 32'd0);
    coal_tmo = 16'd0;

    // reset during COAL, during ASSERT, and an input held high through release
    coal_cnt = 8'd3;
    int_in = 4'b0001; tick(); int_in = 4'b0000; tick();
    int_in = 4'b0010; tick(); int_in = 4'b0000;
    expect4("rst.coal", 4'b0011, 1'b0, 1'b0, 8'd2);
    rst = 1'b1; tick(); expect4("rst.in_coal", 4'b0000, 1'b0, 1'b0, 8'd0);
    rst = 1'b0; tick();
    coal_cnt = 8'd1; int_in = 4'b0100; tick();
    expect4("rst.assert", 4'b0100, 1'b1, 1'b1, 8'd0);
    rst = 1'b1; tick(); expect4("rst.in_assert", 4'b0000, 1'b0, 1'b0, 8'd0);
    tick(); expect4("rst.held", 4'b0000, 1'b0, 1'b0, 8'd0);
    rst = 1'b0; tick(); expect4("rst.release_edge", 4'b0100, 1'b1, 1'b1, 8'd0);
    int_in = 4'b0000; clr = 4'hF; tick(); clr = 4'b0000; tick();
    expect4("rst.clean", 4'b0000, 1'b0, 1'b0, 8'd0);

    // 2-bit counter: 1 event opens the window, 4 more saturate it at 3
    s_int = 5'b00001; tick();
    check("sat.first_cnt", 32'(s_evt), 32'd1);
    check("sat.first_irq", 32'(s_irq), 32'd0);
    s_int = 5'b00000; tick();
    s_int = 5'b11110; tick();
    check("sat.cnt", 32'(s_evt), 32'd3);
    check("sat.irq", 32'(s_irq), 32'd1);
    check("sat.pulse", 32'(s_pulse), 32'd1);
    s_int = 5'b00000; tick();
    check("sat.held", 32'(s_evt), 32'd3);

    // randomized run against the reference model
    rst = 1'b1; tick(); rst = 1'b0;
    m_prev = '0; m_pend = '0; m_fire = 1'b0; m_gath = 1'b0; m_pulse = 1'b0;
    m_cnt = 0; m_age = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int_in = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) mode = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        coal_cnt = 8'($urandom_range(0, 5));
        coal_tmo = 16'($urandom_range(0, 12));
      end
      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin
        m_prev = '0; m_pend = '0; m_fire = 1'b0; m_gath = 1'b0; m_pulse = 1'b0;
        m_cnt = 0; m_age = 0;
      end else begin
        evt = '0; n = 0; act = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (int_in[i] && (mode[i] || !m_prev[i])) evt[i] = 1'b1;
          if (evt[i] && mask[i] && !m_pend[i]) n++;
          if (m_pend[i] && mask[i]) act = 1'b1;
        end
        was_fire = m_fire;
        if (m_fire) begin
          if (!act) begin m_fire = 1'b0; m_cnt = 0; m_age = 0; end
        end else if (m_gath) begin
          m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
          m_age++;
          if (m_cnt >= int'(coal_cnt) || (coal_tmo != 16'd0 && m_age == int'(coal_tmo))) begin
            m_fire = 1'b1; m_gath = 1'b0;
          end else if (!act && n == 0) begin
            m_gath = 1'b0; m_cnt = 0; m_age = 0;
          end
        end else begin
          if (n > 0 && (coal_cnt <= 8'd1 || n >= int'(coal_cnt))) m_fire = 1'b1;
          else if (n > 0) begin m_gath = 1'b1; m_cnt = (n > 255) ? 255 : n; m_age = 0; end
          else if (act) m_fire = 1'b1;
        end
        m_pulse = m_fire && !was_fire;
        m_pend = (m_pend & ~clr) | evt;
        m_prev = int_in;
      end
      tick();
      expect4($sformatf("rnd%0d", cyc), m_pend, m_fire, m_pulse, 8'(m_cnt));
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
